lake_port_harness: RTL and testbench
====================================

# lake_port_harness

Synthesizable multi-port traffic driver and capture checker for lakespec memory tiles. It drives ramp data on NUM_WR ready/valid write ports and consumes NUM_RD read ports under configurable per-port transaction counts, read start delay and static/ready-valid mode. Read data is captured per port, and over-run and timeout failures are flagged. It sits between an on-chip test controller and a lakespec instance, generalising the simulation harness to arbitrary port counts for FPGA and emulation bring-up.

## Interface
- DATA_WIDTH, 16, port data width
- NUM_WR, 2, write (input-to-DUT) port count, 1..8
- NUM_RD, 2, read (output-from-DUT) port count, 1..8
- CNT_WIDTH, 16, transaction/cycle counter width
- MAX_CYCLES, 200, run-length limit in cycles
- CAPTURE_DEPTH, 256, captured words per read port
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a run
- static_mode  in  1  1 = static schedule, 0 = ready/valid checking
- rd_start_delay  in  CNT_WIDTH  cycles before read readys may assert
- wr_num_data  in  NUM_WR*CNT_WIDTH  per-port write transaction target
- rd_num_data  in  NUM_RD*CNT_WIDTH  per-port read transaction target
- wr_data / wr_valid  out  NUM_WR*DATA_WIDTH / NUM_WR  to DUT inputs
- wr_ready  in  NUM_WR  from DUT
- rd_data / rd_valid  in  NUM_RD*DATA_WIDTH / NUM_RD  from DUT outputs
- rd_ready  out  NUM_RD  to DUT
- cap_sel / cap_addr  in  $clog2(NUM_RD) / $clog2(CAPTURE_DEPTH)  capture readback select
- cap_data  out  DATA_WIDTH  captured word, 1-cycle latency
- rd_count  out  NUM_RD*CNT_WIDTH  accepted reads per port
- cycle_count  out  CNT_WIDTH  cycles in current run
- done / pass  out  1 / 1  run finished / finished without error
- err_code  out  2  0 none, 1 read over-run, 2 timeout
- err_port  out  3  read port index of over-run

## Operation
- States: IDLE, RUN, DONE, FAIL.
- IDLE/DONE/FAIL + start -> RUN: all counters, cycle_count, err fields cleared. start in RUN is ignored.
- Write port i in RUN: wr_valid[i] = wr_cnt[i] < wr_num_data[i]; wr_data[i] = (2*wr_cnt[i]) truncated to DATA_WIDTH. wr_valid&wr_ready increments wr_cnt[i].
- Read port j in RUN: rd_ready[j] = (cycle_count >= rd_start_delay) && (static_mode || rd_cnt[j] < rd_num_data[j]). On rd_valid&rd_ready, the word is captured at rd_cnt[j] only if rd_cnt[j] < CAPTURE_DEPTH, and rd_cnt[j] increments, saturating at all-ones.
- Over-run (non-static only): rd_valid[j] with rd_cnt[j] >= rd_num_data[j] -> FAIL, err_code=1, err_port = lowest such j.
- Completion, non-static: all wr_cnt and rd_cnt at target -> DONE, pass=1. If cycle_count reaches MAX_CYCLES first -> FAIL, err_code=2.
- Completion, static: cycle_count reaches MAX_CYCLES -> DONE, pass=1. No over-run check.
- Same-cycle priority: over-run > completion > timeout.
- Outside RUN: all wr_valid and rd_ready are 0.

## Timing
- Reset: state IDLE. All outputs 0: wr_valid, wr_data, rd_ready, done, pass, err_code, err_port, cycle_count, rd_count, cap_data.
- wr_valid, wr_data and rd_ready are decoded from registered state and counters only. There is no combinational path from any input to them.
- cycle_count is 0 in the first RUN cycle and increments each RUN cycle. It is frozen in DONE/FAIL.
- rd_start_delay = 0: rd_ready is high in the first RUN cycle.
- A port with a target of 0 never asserts valid/ready (non-static) and counts as complete immediately.
- done = state is DONE or FAIL. pass = state is DONE.
- rst mid-run returns to IDLE next edge. Capture contents are not cleared.

## Configuration
- LAKE_HARNESS_CAPTURE_EN defined: per-read-port capture RAMs exist and cap_data returns the word at (cap_sel, cap_addr) one cycle after the address is presented.
- Not defined: no RAMs are built and cap_data is tied to 0. Counting, checking and handshakes are unchanged.

## Structure
- Package lake_harness_pkg holds:
  - the state enum (IDLE/RUN/DONE/FAIL);
  - the err_code enum;
  - localparams for the port-count upper bound (8) and err_port width.
- Sub-module lake_harness_capture_mem: single-write, single-read synchronous RAM, DATA_WIDTH x CAPTURE_DEPTH. One instance per read port, generated only under LAKE_HARNESS_CAPTURE_EN.

## Test plan
- NUM_WR=NUM_RD=1, loopback FIFO DUT, wr/rd_num_data=10, static_mode=0 -> done and pass after all 10 transfers; captures 0,2,…,18; rd_count=10.
- rd_start_delay=64, FIFO depth 8 -> rd_ready low for cycles 0-63; wr_cnt stalls at 8 until reads start; final pass.
- DUT asserts rd_valid after 10th read with rd_num_data=10 -> FAIL, err_code=1, err_port=0, rd_ready low afterwards.
- rd_num_data=300, DUT idles, MAX_CYCLES=200 -> FAIL, err_code=2, cycle_count=200.
- static_mode=1, NUM_RD=2 -> rd_ready high from rd_start_delay until cycle 200; DONE with pass regardless of counts; extra reads are captured without error.
- rst asserted at cycle 50 of a run, then start -> IDLE with all outputs 0; rerun passes with counters restarted from 0.

Source files
------------

// File: rtl/lake_harness_pkg.sv
// Shared types for the lakespec port harness: run state, error codes and port limits.
// The optional capture RAMs are enabled by defining LAKE_HARNESS_CAPTURE_EN.
package lake_harness_pkg;

  localparam int MAX_PORTS  = 8;
  localparam int ERR_PORT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OVERRUN = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

endpackage

// File: rtl/lake_harness_capture_mem.sv
// Single-write, single-read synchronous RAM holding captured read-port words.
// Instantiated per read port only when LAKE_HARNESS_CAPTURE_EN is defined.
module lake_harness_capture_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lake_port_harness.sv
// Multi-port ramp-write / capture-read traffic harness for lakespec tiles.
// Define LAKE_HARNESS_CAPTURE_EN to build per-read-port capture RAMs behind cap_data.
module lake_port_harness
  import lake_harness_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_WR        = 2,
  parameter int NUM_RD        = 2,
  parameter int CNT_WIDTH     = 16,
  parameter int MAX_CYCLES    = 200,
  parameter int CAPTURE_DEPTH = 256,
  localparam int SEL_W        = (NUM_RD > 1) ? $clog2(NUM_RD) : 1,
  localparam int ADDR_W       = (CAPTURE_DEPTH > 1) ? $clog2(CAPTURE_DEPTH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            static_mode,
  input  logic [CNT_WIDTH-1:0]            rd_start_delay,
  input  logic [NUM_WR*CNT_WIDTH-1:0]     wr_num_data,
  input  logic [NUM_RD*CNT_WIDTH-1:0]     rd_num_data,
  output logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
  output logic [NUM_WR-1:0]               wr_valid,
  input  logic [NUM_WR-1:0]               wr_ready,
  input  logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
  input  logic [NUM_RD-1:0]               rd_valid,
  output logic [NUM_RD-1:0]               rd_ready,
  input  logic [SEL_W-1:0]                cap_sel,
  input  logic [ADDR_W-1:0]               cap_addr,
  output logic [DATA_WIDTH-1:0]           cap_data,
  output logic [NUM_RD*CNT_WIDTH-1:0]     rd_count,
  output logic [CNT_WIDTH-1:0]            cycle_count,
  output logic                            done,
  output logic                            pass,
  output logic [1:0]                      err_code,
  output logic [ERR_PORT_W-1:0]           err_port
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CYC_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_wr_cnt    [NUM_WR];
  logic [CNT_WIDTH-1:0]   r_wr_target [NUM_WR];
  logic [CNT_WIDTH-1:0]   r_rd_cnt    [NUM_RD];
  logic [CNT_WIDTH-1:0]   r_rd_target [NUM_RD];
  logic [CNT_WIDTH-1:0]   r_delay;
  logic [CNT_WIDTH-1:0]   r_cycle_count;
  logic                   r_static;
  logic                   r_done;
  logic                   r_pass;
  err_t                   r_err_code;
  logic [ERR_PORT_W-1:0]  r_err_port;

  logic                   w_run;
  logic                   w_rd_window;
  logic                   w_all_done;
  logic                   w_timeout;
  logic [NUM_WR-1:0]      w_wr_pending;
  logic [NUM_WR-1:0]      w_wr_fire;
  logic [NUM_RD-1:0]      w_rd_pending;
  logic [NUM_RD-1:0]      w_rd_fire;
  logic [NUM_RD-1:0]      w_overrun;
  logic [ERR_PORT_W-1:0]  w_overrun_port;

  // Targets and mode are latched at start so handshake outputs depend on registers only.
  assign w_run       = (r_state == ST_RUN);
  assign w_rd_window = (r_cycle_count >= r_delay);
  assign w_all_done  = ~|w_wr_pending && ~|w_rd_pending;
  assign w_timeout   = (r_cycle_count >= CYC_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      assign w_wr_pending[gi] = (r_wr_cnt[gi] < r_wr_target[gi]);
      assign wr_valid[gi]     = w_run && w_wr_pending[gi];
      assign wr_data[gi*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'({r_wr_cnt[gi], 1'b0});
      assign w_wr_fire[gi]    = wr_valid[gi] && wr_ready[gi];
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      assign w_rd_pending[gi] = (r_rd_cnt[gi] < r_rd_target[gi]);
      assign rd_ready[gi]     = w_run && w_rd_window && (r_static || w_rd_pending[gi]);
      assign w_rd_fire[gi]    = rd_ready[gi] && rd_valid[gi];
      assign w_overrun[gi]    = w_run && !r_static && rd_valid[gi] && !w_rd_pending[gi];
      assign rd_count[gi*CNT_WIDTH +: CNT_WIDTH] = r_rd_cnt[gi];
    end
  endgenerate

  always_comb begin
    w_overrun_port = '0;
    for (int j = NUM_RD - 1; j >= 0; j--) begin
      if (w_overrun[j] && (j < MAX_PORTS)) begin
        w_overrun_port = ERR_PORT_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cycle_count <= '0;
      r_delay       <= '0;
      r_static      <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_err_port    <= '0;
      for (int i = 0; i < NUM_WR; i++) begin
        r_wr_cnt[i]    <= '0;
        r_wr_target[i] <= '0;
      end
      for (int j = 0; j < NUM_RD; j++) begin
        r_rd_cnt[j]    <= '0;
        r_rd_target[j] <= '0;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          r_cycle_count <= r_cycle_count + CNT_ONE;
          for (int i = 0; i < NUM_WR; i++) begin
            if (w_wr_fire[i]) r_wr_cnt[i] <= r_wr_cnt[i] + CNT_ONE;
          end
          for (int j = 0; j < NUM_RD; j++) begin
            if (w_rd_fire[j] && (r_rd_cnt[j] != '1)) r_rd_cnt[j] <= r_rd_cnt[j] + CNT_ONE;
          end
          // Over-run beats completion, which beats timeout.
          if (|w_overrun) begin
            r_state    <= ST_FAIL;
            r_done     <= 1'b1;
            r_pass     <= 1'b0;
            r_err_code <= ERR_OVERRUN;
            r_err_port <= w_overrun_port;
          end else if (!r_static && w_all_done) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (w_timeout) begin
            r_done <= 1'b1;
            if (r_static) begin
              r_state <= ST_DONE;
              r_pass  <= 1'b1;
            end else begin
              r_state    <= ST_FAIL;
              r_pass     <= 1'b0;
              r_err_code <= ERR_TIMEOUT;
            end
          end
        end
        default: begin
          if (start) begin
            r_state       <= ST_RUN;
            r_cycle_count <= '0;
            r_delay       <= rd_start_delay;
            r_static      <= static_mode;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_err_port    <= '0;
            for (int i = 0; i < NUM_WR; i++) begin
              r_wr_cnt[i]    <= '0;
              r_wr_target[i] <= wr_num_data[i*CNT_WIDTH +: CNT_WIDTH];
            end
            for (int j = 0; j < NUM_RD; j++) begin
              r_rd_cnt[j]    <= '0;
              r_rd_target[j] <= rd_num_data[j*CNT_WIDTH +: CNT_WIDTH];
            end
          end
        end
      endcase
    end
  end

  assign cycle_count = r_cycle_count;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_code    = r_err_code;
  assign err_port    = r_err_port;

`ifdef LAKE_HARNESS_CAPTURE_EN
  logic [DATA_WIDTH-1:0] w_cap_rd [NUM_RD];
  logic [SEL_W-1:0]      r_cap_sel;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_cap
      lake_harness_capture_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CAPTURE_DEPTH)
      ) u_mem (
        .clk       (clk),
        .i_rst     (rst),
        .i_wr_en   (w_rd_fire[gi] && ({1'b0, r_rd_cnt[gi]} < (CNT_WIDTH+1)'(CAPTURE_DEPTH))),
        .i_wr_addr (ADDR_W'(r_rd_cnt[gi])),
        .i_wr_data (rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .i_rd_addr (cap_addr),
        .o_rd_data (w_cap_rd[gi])
      );
    end
  endgenerate

  // Select is registered alongside the RAM read so both line up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_sel <= '0;
    end else begin
      r_cap_sel <= cap_sel;
    end
  end

  assign cap_data = (32'(r_cap_sel) < NUM_RD) ? w_cap_rd[r_cap_sel] : '0;
`else
  logic w_unused_cap;
  assign w_unused_cap = ^{cap_sel, cap_addr, rd_data};
  assign cap_data     = '0;
`endif

endmodule

// File: tb/tb_lake_port_harness.sv
// Directed bench for lake_port_harness with a loopback FIFO model per port pair.
// Capture readback is checked against the ramp when LAKE_HARNESS_CAPTURE_EN is defined.
module tb_lake_port_harness;
  import lake_harness_pkg::*;

  localparam int DW = 16;
  localparam int NW = 2;
  localparam int NR = 2;
  localparam int CW = 16;
  localparam int FD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, static_mode;
  logic [CW-1:0]     rd_start_delay;
  logic [NW*CW-1:0]  wr_num_data;
  logic [NR*CW-1:0]  rd_num_data;
  logic [NW*DW-1:0]  wr_data;
  logic [NW-1:0]     wr_valid, wr_ready;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_valid, rd_ready;
  logic [0:0]        cap_sel;
  logic [7:0]        cap_addr;
  logic [DW-1:0]     cap_data;
  logic [NR*CW-1:0]  rd_count;
  logic [CW-1:0]     cycle_count;
  logic              done, pass;
  logic [1:0]        err_code;
  logic [2:0]        err_port;

  lake_port_harness #(
    .DATA_WIDTH(DW), .NUM_WR(NW), .NUM_RD(NR), .CNT_WIDTH(CW),
    .MAX_CYCLES(200), .CAPTURE_DEPTH(256)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .static_mode(static_mode),
    .rd_start_delay(rd_start_delay), .wr_num_data(wr_num_data), .rd_num_data(rd_num_data),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .cap_sel(cap_sel), .cap_addr(cap_addr), .cap_data(cap_data),
    .rd_count(rd_count), .cycle_count(cycle_count), .done(done), .pass(pass),
    .err_code(err_code), .err_port(err_port)
  );

  int checks = 0;
  int errors = 0;

  // Loopback FIFO model: write port i feeds read port i; m_en=0 makes the tile idle.
  logic          m_en;
  logic [DW-1:0] f_mem [NR][FD];
  int            f_cnt [NR];
  int            f_rp  [NR];
  int            f_wp  [NR];
  logic [NW-1:0] t_wf;
  logic [NR-1:0] t_rf;

  assign t_wf = wr_valid & wr_ready;
  assign t_rf = rd_valid & rd_ready;

  genvar gi;
  for (gi = 0; gi < NR; gi++) begin : g_model
    assign wr_ready[gi] = m_en && (f_cnt[gi] < FD);
    assign rd_valid[gi] = m_en && (f_cnt[gi] > 0);
    assign rd_data[gi*DW +: DW] = f_mem[gi][f_rp[gi]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rst) begin
        f_cnt[i] <= 0;
        f_rp[i]  <= 0;
        f_wp[i]  <= 0;
      end else begin
        if (t_wf[i]) begin
          f_mem[i][f_wp[i]] <= wr_data[i*DW +: DW];
          f_wp[i] <= (f_wp[i] + 1) % FD;
        end
        if (t_rf[i]) f_rp[i] <= (f_rp[i] + 1) % FD;
        f_cnt[i] <= f_cnt[i] + (t_wf[i] ? 1 : 0) - (t_rf[i] ? 1 : 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected ramp words are queued at start and popped on each write handshake.
  logic [DW-1:0] exp_wr [NW][$];
  logic [DW-1:0] mon_v;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NW; i++) begin
        if (wr_valid[i] && wr_ready[i]) begin
          if (exp_wr[i].size() == 0) begin
            checks++;
            errors++;
            $error("FAIL wr_extra port=%0d observed=%0h required=none", i, wr_data[i*DW +: DW]);
          end else begin
            mon_v = exp_wr[i].pop_front();
            chk($sformatf("wr_data_p%0d", i), 32'(wr_data[i*DW +: DW]), 32'(mon_v));
          end
        end
      end
    end
  end

  task automatic clear_exp();
    for (int i = 0; i < NW; i++) exp_wr[i].delete();
  endtask

  task automatic run_start(input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                           input logic [CW-1:0] r0, input logic [CW-1:0] r1,
                           input logic [CW-1:0] dly, input logic st);
    wr_num_data    = {w1, w0};
    rd_num_data    = {r1, r0};
    rd_start_delay = dly;
    static_mode    = st;
    for (int k = 0; k < int'(w0); k++) exp_wr[0].push_back(DW'(2 * k));
    for (int k = 0; k < int'(w1); k++) exp_wr[1].push_back(DW'(2 * k));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s_wait observed=done0 required=done1 within %0d cycles", tag, lim);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_exp();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_rd_ready"}, 32'(rd_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_err_port"}, 32'(err_port), 32'd0);
    chk({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
    chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
    chk({tag, "_cap_data"}, 32'(cap_data), 32'd0);
  endtask

  task automatic cap_check(input string tag, input int port, input int n);
    for (int k = 0; k < n; k++) begin
      cap_sel  = 1'(port);
      cap_addr = 8'(k);
      @(negedge clk);
`ifdef LAKE_HARNESS_CAPTURE_EN
      chk($sformatf("%s_cap%0d", tag, k), 32'(cap_data), 32'(2 * k));
`else
      chk($sformatf("%s_cap%0d", tag, k), 32'(cap_data), 32'd0);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; static_mode = 1'b0; rd_start_delay = '0;
    wr_num_data = '0; rd_num_data = '0; cap_sel = '0; cap_addr = '0; m_en = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // t1: single loopback, 10 transfers
    run_start(16'd10, 16'd0, 16'd10, 16'd0, 16'd0, 1'b0);
    wait_done(400, "t1");
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_err_code", 32'(err_code), 32'(ERR_NONE));
    chk("t1_rd_count0", 32'(rd_count[CW-1:0]), 32'd10);
    chk("t1_rd_count1", 32'(rd_count[2*CW-1:CW]), 32'd0);
    chk("t1_cycles", 32'(cycle_count), 32'd12);
    chk("t1_wr_left", 32'(exp_wr[0].size()), 32'd0);
    $display("run t1 done=%0d pass=%0d err=%0d rd_count0=%0d cycles=%0d",
             done, pass, err_code, rd_count[CW-1:0], cycle_count);
    cap_check("t1", 0, 10);

    // t2: read start delay 64 against an 8-deep FIFO, started straight from DONE
    run_start(16'd10, 16'd0, 16'd10, 16'd0, 16'd64, 1'b0);
    for (int c = 0; c < 64; c++) begin
      chk($sformatf("t2_rdy_low_c%0d", c), 32'(rd_ready), 32'd0);
      @(negedge clk);
    end
    chk("t2_rdy_high_c64", 32'(rd_ready[0]), 32'd1);
    chk("t2_wr_stall_left", 32'(exp_wr[0].size()), 32'd2);
    chk("t2_wr_valid_c64", 32'(wr_valid[0]), 32'd1);
    wait_done(400, "t2");
    chk("t2_pass", 32'(pass), 32'd1);
    chk("t2_rd_count0", 32'(rd_count[CW-1:0]), 32'd10);
    chk("t2_wr_left", 32'(exp_wr[0].size()), 32'd0);
    $display("run t2 done=%0d pass=%0d rd_count0=%0d", done, pass, rd_count[CW-1:0]);

    // t3: port 0 over-run (extra data behind 10 reads)
    run_start(16'd20, 16'd0, 16'd10, 16'd0, 16'd0, 1'b0);
    wait_done(400, "t3");
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_pass", 32'(pass), 32'd0);
    chk("t3_err_code", 32'(err_code), 32'(ERR_OVERRUN));
    chk("t3_err_port", 32'(err_port), 32'd0);
    chk("t3_rd_count0", 32'(rd_count[CW-1:0]), 32'd10);
    @(negedge clk);
    chk("t3_rd_ready_after", 32'(rd_ready), 32'd0);
    chk("t3_wr_valid_after", 32'(wr_valid), 32'd0);
    $display("run t3 done=%0d pass=%0d err=%0d port=%0d", done, pass, err_code, err_port);
    do_reset();

    // t3b: same over-run on port 1 only
    run_start(16'd0, 16'd20, 16'd0, 16'd10, 16'd0, 1'b0);
    wait_done(400, "t3b");
    chk("t3b_err_code", 32'(err_code), 32'(ERR_OVERRUN));
    chk("t3b_err_port", 32'(err_port), 32'd1);
    chk("t3b_rd_count1", 32'(rd_count[2*CW-1:CW]), 32'd10);
    $display("run t3b done=%0d pass=%0d err=%0d port=%0d", done, pass, err_code, err_port);
    clear_exp();

    // t4: idle tile with 300 reads wanted -> timeout, started from FAIL
    m_en = 1'b0;
    run_start(16'd0, 16'd0, 16'd300, 16'd0, 16'd0, 1'b0);
    wait_done(300, "t4");
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd0);
    chk("t4_err_code", 32'(err_code), 32'(ERR_TIMEOUT));
    chk("t4_cycle_count", 32'(cycle_count), 32'd200);
    chk("t4_rd_count0", 32'(rd_count[CW-1:0]), 32'd0);
    $display("run t4 done=%0d pass=%0d err=%0d cycles=%0d", done, pass, err_code, cycle_count);
    m_en = 1'b1;
    do_reset();

    // t5: static schedule on both ports, extra reads beyond the targets
    run_start(16'd10, 16'd10, 16'd3, 16'd3, 16'd20, 1'b1);
    for (int c = 0; c <= 200; c++) begin
      if (c == 19) chk("t5_rdy_c19", 32'(rd_ready), 32'd0);
      if (c == 20) chk("t5_rdy_c20", 32'(rd_ready), 32'd3);
      if (c == 199) begin
        chk("t5_rdy_c199", 32'(rd_ready), 32'd3);
        chk("t5_done_c199", 32'(done), 32'd0);
      end
      if (c == 200) begin
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_pass", 32'(pass), 32'd1);
        chk("t5_err_code", 32'(err_code), 32'(ERR_NONE));
        chk("t5_cycle_count", 32'(cycle_count), 32'd200);
        chk("t5_rdy_c200", 32'(rd_ready), 32'd0);
        chk("t5_rd_count0", 32'(rd_count[CW-1:0]), 32'd10);
        chk("t5_rd_count1", 32'(rd_count[2*CW-1:CW]), 32'd10);
      end else begin
        @(negedge clk);
      end
    end
    chk("t5_wr_left", 32'(exp_wr[0].size() + exp_wr[1].size()), 32'd0);
    $display("run t5 done=%0d pass=%0d rd_count=%0d/%0d", done, pass,
             rd_count[CW-1:0], rd_count[2*CW-1:CW]);
    cap_check("t5p1", 1, 10);

    // t6: reset at cycle 50 of a long run, then a clean rerun
    run_start(16'd100, 16'd0, 16'd100, 16'd0, 16'd0, 1'b0);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("t6_rst");
    rst = 1'b0;
    clear_exp();
    @(negedge clk);
    run_start(16'd10, 16'd0, 16'd10, 16'd0, 16'd0, 1'b0);
    wait_done(400, "t6");
    chk("t6_pass", 32'(pass), 32'd1);
    chk("t6_rd_count0", 32'(rd_count[CW-1:0]), 32'd10);
    chk("t6_cycles", 32'(cycle_count), 32'd12);
    chk("t6_wr_left", 32'(exp_wr[0].size()), 32'd0);
    $display("run t6 done=%0d pass=%0d rd_count0=%0d", done, pass, rd_count[CW-1:0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
